time_uart_send: RTL and testbench
=================================

TIME_UART_SEND -- requirements
Module: time_uart_send

Interface
REQ-001 Parameter SEP_CHAR, default 8'h3A, separator byte placed between fields.
REQ-002 Parameter EOL_EN, default 1: 1 appends CR LF (10-byte frame); 0 gives an 8-byte frame.
REQ-003 Clk  input  1  system clock; all logic rising-edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 send_req  input  1  one-cycle request to transmit one time frame.
REQ-006 hour  input  8  BCD hours, [7:4] tens, [3:0] units.
REQ-007 min  input  8  BCD minutes.
REQ-008 sec  input  8  BCD seconds.
REQ-009 tx_busy  input  1  busy flag from the downstream UART transmitter.
REQ-010 tx_done  input  1  one-cycle byte-complete pulse from the UART transmitter.
REQ-011 tx_en  output  1  one-cycle byte-start strobe to the UART transmitter.
REQ-012 tx_data  output  8  byte to send; valid in the tx_en cycle.
REQ-013 busy  output  1  high from frame acceptance until frame completion.
REQ-014 done  output  1  one-cycle pulse when the last byte's tx_done is seen.

Function
REQ-015 Frame order: hour tens, hour units, SEP_CHAR, min tens, min units, SEP_CHAR, sec tens, sec units, then 8'h0D, 8'h0A if EOL_EN=1.
REQ-016 Digit encoding: nibble 0-9 -> 8'h30 + nibble; nibble 10-15 -> 8'h3F ('?').
REQ-017 hour/min/sec are latched in the cycle send_req is accepted; later input changes do not affect the current frame.
REQ-018 FSM states: IDLE, SEND, WAIT.
REQ-019 IDLE: send_req=1 -> latch inputs, byte index=0, busy=1 next cycle, go to SEND; otherwise stay.
REQ-020 SEND: tx_busy=0 -> tx_en=1 for exactly one cycle, tx_data=byte[index], go to WAIT; tx_busy=1 -> stay, tx_en=0.
REQ-021 WAIT: tx_done=1 and index=LEN-1 -> done=1 for one cycle, busy=0, go to IDLE.
REQ-022 WAIT: tx_done=1 and index<LEN-1 -> index+1, go to SEND.
REQ-023 WAIT: tx_done=0 -> stay.
REQ-024 tx_en and tx_data are registered outputs; tx_data holds the last sent byte between strobes.
REQ-025 Back-to-back bytes: with a transmitter whose tx_busy falls the cycle after tx_done, the next tx_en is issued 2 cycles after tx_done.
REQ-026 send_req while busy=1 is ignored and is not queued.
REQ-027 send_req in the same cycle as done=1 is ignored; a new request is accepted only in IDLE.
REQ-028 The byte index is 4 bits and never exceeds LEN-1.
REQ-029 tx_done seen outside WAIT is ignored.

Reset
REQ-030 Rst_n=0 forces IDLE, index=0, tx_en=0, tx_data=8'h00, busy=0, done=0, latched time=0, asynchronously.
REQ-031 Reset asserted mid-frame aborts the frame with no done pulse; after release the block waits in IDLE for a new send_req.

Verification
REQ-032 hour=8'h12, min=8'h34, sec=8'h56, send_req pulse, with the real UART transmitter (434 cycles/bit) -> bytes 31 32 3A 33 34 3A 35 36 0D 0A, exactly one done pulse, busy high throughout.
REQ-033 EOL_EN=0, time 23:59:07 -> bytes 32 33 3A 35 39 3A 30 37, done after the 8th tx_done.
REQ-034 hour=8'h1A -> first two bytes 31 3F.
REQ-035 Change inputs after acceptance and pulse send_req again mid-frame -> frame uses the original values, no second frame, a single done.
REQ-036 Hold tx_busy=1 externally in SEND -> no tx_en until tx_busy falls, then exactly one tx_en.
REQ-037 Assert Rst_n=0 after the 4th byte -> all outputs at reset values immediately, no done; a new send_req then yields a full, correct frame.

Source files
------------

// File: rtl/time_uart_send.sv
// Serialises a latched BCD time as ASCII "HH<sep>MM<sep>SS[CR LF]" into a byte-wide UART transmitter.
// One byte per tx_en strobe; the next byte starts 2 cycles after tx_done, and the block stalls while tx_busy is high.
module time_uart_send #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter int         EOL_EN   = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       send_req,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = (EOL_EN != 0) ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cur_byte;

  // Non-decimal nibbles are shown as '?' so corrupt BCD is visible on the wire.
  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      digit_ascii = 8'h30 + {4'h0, nib};
    end else begin
      digit_ascii = 8'h3F;
    end
  endfunction

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = digit_ascii(hour_q[7:4]);
      4'd1:    cur_byte = digit_ascii(hour_q[3:0]);
      4'd2:    cur_byte = SEP_CHAR;
      4'd3:    cur_byte = digit_ascii(min_q[7:4]);
      4'd4:    cur_byte = digit_ascii(min_q[3:0]);
      4'd5:    cur_byte = SEP_CHAR;
      4'd6:    cur_byte = digit_ascii(sec_q[7:4]);
      4'd7:    cur_byte = digit_ascii(sec_q[3:0]);
      4'd8:    cur_byte = 8'h0D;
      4'd9:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A request coinciding with the completion pulse belongs to the old frame and is dropped.
        if (send_req && !done_q) begin
          hour_d  = hour;
          min_d   = min;
          sec_d   = sec;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = cur_byte;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      hour_q    <= 8'h00;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_time_uart_send.sv
// Bench for time_uart_send: a 10-byte and an 8-byte instance, each driving a behavioural UART model;
// expected bytes are queued at request time and matched against bytes captured on tx_en.
module tb_time_uart_send;

  localparam int BYTE_CYC = 20;
  localparam int TIMEOUT  = 3000;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] hour, min, sec;
  logic       hold_a;

  logic       tx_en_a, tx_en_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       tx_busy_a, tx_busy_b, tx_done_a, tx_done_b;
  logic [7:0] cnt_a, cnt_b;

  int vectors;
  int miscompares;
  int done_cnt_a, done_cnt_b;
  logic [7:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  time_uart_send #(.SEP_CHAR(8'h3A), .EOL_EN(1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .send_req(req_a), .hour(hour), .min(min), .sec(sec),
    .tx_busy(tx_busy_a), .tx_done(tx_done_a), .tx_en(tx_en_a), .tx_data(tx_data_a),
    .busy(busy_a), .done(done_a)
  );

  time_uart_send #(.SEP_CHAR(8'h3A), .EOL_EN(0)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .send_req(req_b), .hour(hour), .min(min), .sec(sec),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b), .tx_en(tx_en_b), .tx_data(tx_data_b),
    .busy(busy_b), .done(done_b)
  );

  // UART models: busy for BYTE_CYC cycles, one-cycle done, busy drops the cycle after done.
  assign tx_busy_a = (cnt_a != 8'd0) || tx_done_a || hold_a;
  assign tx_busy_b = (cnt_b != 8'd0) || tx_done_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 8'd0; tx_done_a <= 1'b0;
      cnt_b <= 8'd0; tx_done_b <= 1'b0;
    end else begin
      tx_done_a <= (cnt_a == 8'd1);
      tx_done_b <= (cnt_b == 8'd1);
      if (tx_en_a) cnt_a <= 8'(BYTE_CYC); else if (cnt_a != 8'd0) cnt_a <= cnt_a - 8'd1;
      if (tx_en_b) cnt_b <= 8'(BYTE_CYC); else if (cnt_b != 8'd0) cnt_b <= cnt_b - 8'd1;
    end
  end

  always @(negedge clk) begin
    if (tx_en_a) obs_a.push_back(tx_data_a);
    if (tx_en_b) obs_b.push_back(tx_data_b);
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  function automatic logic [7:0] enc(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : 8'h3F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_frame(input int inst, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    logic [7:0] f[10];
    f = '{enc(h[7:4]), enc(h[3:0]), 8'h3A, enc(m[7:4]), enc(m[3:0]), 8'h3A,
          enc(s[7:4]), enc(s[3:0]), 8'h0D, 8'h0A};
    for (int i = 0; i < ((inst == 0) ? 10 : 8); i++) begin
      if (inst == 0) exp_a.push_back(f[i]); else exp_b.push_back(f[i]);
    end
  endtask

  task automatic start_frame(input int inst, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour = h; min = m; sec = s;
    push_frame(inst, h, m, s);
    if (inst == 0) req_a = 1'b1; else req_b = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic wait_done(input int inst, input string tag, input bit req_at_done);
    int  gaps;
    int  start;
    bit  seen;
    gaps  = 0;
    seen  = 1'b0;
    start = (inst == 0) ? done_cnt_a : done_cnt_b;
    for (int c = 0; c < TIMEOUT && !seen; c++) begin
      @(negedge clk); #1;
      if ((inst == 0) ? done_a : done_b) seen = 1'b1;
      else if (!((inst == 0) ? busy_a : busy_b)) gaps++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_gaps"}, gaps, 0);
    if (req_at_done) begin
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
    end
    repeat (3 * BYTE_CYC) @(negedge clk);
    chk({tag, "_done_count"}, ((inst == 0) ? done_cnt_a : done_cnt_b) - start, 1);
  endtask

  task automatic check_frame(input int inst, input string tag);
    logic [7:0] e, o;
    int n;
    n = (inst == 0) ? exp_a.size() : exp_b.size();
    for (int i = 0; i < n; i++) begin
      e = (inst == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if (((inst == 0) ? obs_a.size() : obs_b.size()) == 0) begin
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'hDEAD, {24'h0, e});
      end else begin
        o = (inst == 0) ? obs_a.pop_front() : obs_b.pop_front();
        chk($sformatf("%s_byte%0d", tag, i), {24'h0, o}, {24'h0, e});
      end
    end
    chk({tag, "_extra_bytes"}, (inst == 0) ? obs_a.size() : obs_b.size(), 0);
  endtask

  initial begin
    int d0;
    vectors = 0; miscompares = 0;
    done_cnt_a = 0; done_cnt_b = 0;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; hold_a = 1'b0;
    hour = 8'h00; min = 8'h00; sec = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx_en", 32'(tx_en_a), 0);
    chk("rst_tx_data", {24'h0, tx_data_a}, 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_b_outs", {20'h0, tx_en_b, busy_b, done_b, 1'b0, tx_data_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 12:34:56 with CR LF
    start_frame(0, 8'h12, 8'h34, 8'h56);
    wait_done(0, "f1234", 1'b0);
    check_frame(0, "f1234");
    chk("hold_last_byte", {24'h0, tx_data_a}, 32'h0A);

    // 8-byte frame 23:59:07
    start_frame(1, 8'h23, 8'h59, 8'h07);
    wait_done(1, "f2359", 1'b0);
    check_frame(1, "f2359");

    // Non-BCD nibbles; a request on the done cycle must be dropped
    start_frame(0, 8'h1A, 8'h09, 8'hFF);
    wait_done(0, "f1A", 1'b1);
    check_frame(0, "f1A");
    chk("req_at_done_busy", 32'(busy_a), 0);

    // Inputs change and a second request arrives mid-frame
    start_frame(0, 8'h01, 8'h02, 8'h03);
    for (int c = 0; c < TIMEOUT && obs_a.size() < 3; c++) @(negedge clk);
    hour = 8'h09; min = 8'h08; sec = 8'h07;
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    wait_done(0, "fmid", 1'b0);
    check_frame(0, "fmid");

    // Transmitter held busy before the first byte
    hold_a = 1'b1;
    start_frame(0, 8'h20, 8'h00, 8'h45);
    repeat (40) @(negedge clk);
    chk("hold_no_tx", obs_a.size(), 0);
    chk("hold_busy", 32'(busy_a), 1);
    hold_a = 1'b0;
    wait_done(0, "fhold", 1'b0);
    check_frame(0, "fhold");

    // Reset after the fourth byte aborts the frame
    start_frame(0, 8'h11, 8'h22, 8'h33);
    for (int c = 0; c < TIMEOUT && obs_a.size() < 4; c++) @(negedge clk);
    repeat (BYTE_CYC / 2) @(negedge clk);
    d0 = done_cnt_a;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outs", {21'h0, tx_en_a, busy_a, done_a, tx_data_a}, 0);
    exp_a.delete();
    obs_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BYTE_CYC) @(negedge clk);
    chk("abort_no_done", done_cnt_a - d0, 0);
    chk("abort_idle", {30'h0, busy_a, tx_en_a}, 0);
    chk("abort_no_bytes", obs_a.size(), 0);
    start_frame(0, 8'h08, 8'h30, 8'h59);
    wait_done(0, "fpost", 1'b0);
    check_frame(0, "fpost");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
